// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode, funct, ALU codes and controller state encoding for the multicycle MIPS
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU operation codes, shared with the ALU itself
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_NONE,
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALU operation class and funct field to the 3-bit ALU control code
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    logic [2:0] funct_code;

    always_comb begin
        funct_code  = ALU_AND;
        funct_valid = 1'b1;
        case (funct)
            F_ADD:   funct_code = ALU_ADD;
            F_SUB:   funct_code = ALU_SUB;
            F_AND:   funct_code = ALU_AND;
            F_OR:    funct_code = ALU_OR;
            F_SLT:   funct_code = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_control = ALU_AND;
        case (alu_op_t'(alu_op))
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_code;
            default:     alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore FSM sequencing the multicycle MIPS datapath
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_instr
);

    state_t  state, state_next;
    alu_op_t alu_op;
    logic    funct_valid;
    logic    pc_write, branch, illegal;
    logic    ir_wr, mem_wr, reg_wr;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        alu_op     = ALUOP_NONE;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_wr      = 1'b1;
                alu_src_b  = 2'b01;
                alu_op     = ALUOP_ADD;
                pc_write   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alu_src_b = 2'b11;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    OP_RTYPE: begin
                        if (funct_valid) state_next = S_RTYPEEX;
                        else             illegal    = 1'b1;
                    end
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = ALUOP_ADD;
                state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_wr     = 1'b1;
            end
            S_MEMWR: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_dst = 1'b1;
                reg_wr  = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = ALUOP_ADD;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_wr = 1'b1;
            end
            S_JEX: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Write enables are gated by reset so an aborted instruction leaves no side effects
    assign pc_en         = (pc_write | (branch & zero)) & ~reset;
    assign ir_write      = ir_wr & ~reset;
    assign mem_write     = mem_wr & ~reset;
    assign reg_write     = reg_wr & ~reset;
    assign illegal_instr = illegal & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for the multicycle MIPS controller
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_instr;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_instr;

    outs_t obs;
    outs_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    assign obs = {alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, illegal_instr};

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .alu_control   (alu_control),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .pc_en         (pc_en),
        .iord          (iord),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic outs_t fetch_cycle();
        outs_t o = '0;
        o.alu_control = 3'b010;
        o.alu_src_b   = 2'b01;
        o.pc_en       = 1'b1;
        o.ir_write    = 1'b1;
        return o;
    endfunction

    function automatic outs_t addr_calc();
        outs_t o = '0;
        o.alu_control = 3'b010;
        o.alu_src_a   = 1'b1;
        o.alu_src_b   = 2'b10;
        return o;
    endfunction

    // Reference: per-cycle expected outputs of a whole instruction, from the instruction semantics
    function automatic void build_trace(input logic [5:0] op, input logic [5:0] fn, input logic z);
        outs_t o;
        logic [2:0] rcode;
        logic       rvalid;
        exp_q.delete();
        exp_q.push_back(fetch_cycle());
        o = '0;
        o.alu_control = 3'b010;
        o.alu_src_b   = 2'b11;
        rvalid = 1'b1;
        rcode  = 3'b000;
        case (fn)
            6'd32:   rcode = 3'b010;
            6'd34:   rcode = 3'b110;
            6'd36:   rcode = 3'b000;
            6'd37:   rcode = 3'b001;
            6'd42:   rcode = 3'b111;
            default: rvalid = 1'b0;
        endcase
        if (op == 6'd35) begin
            exp_q.push_back(o);
            exp_q.push_back(addr_calc());
            o = '0; o.iord = 1'b1;
            exp_q.push_back(o);
            o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1;
            exp_q.push_back(o);
        end else if (op == 6'd43) begin
            exp_q.push_back(o);
            exp_q.push_back(addr_calc());
            o = '0; o.iord = 1'b1; o.mem_write = 1'b1;
            exp_q.push_back(o);
        end else if (op == 6'd0 && rvalid) begin
            exp_q.push_back(o);
            o = '0; o.alu_src_a = 1'b1; o.alu_control = rcode;
            exp_q.push_back(o);
            o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1;
            exp_q.push_back(o);
        end else if (op == 6'd4) begin
            exp_q.push_back(o);
            o = '0; o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.pc_src = 2'b01; o.pc_en = z;
            exp_q.push_back(o);
        end else if (op == 6'd8) begin
            exp_q.push_back(o);
            exp_q.push_back(addr_calc());
            o = '0; o.reg_write = 1'b1;
            exp_q.push_back(o);
        end else if (op == 6'd2) begin
            exp_q.push_back(o);
            o = '0; o.pc_src = 2'b10; o.pc_en = 1'b1;
            exp_q.push_back(o);
        end else begin
            o.illegal_instr = 1'b1;
            exp_q.push_back(o);
        end
    endfunction

    task automatic check(input string tag, input outs_t e);
        @(negedge clk);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input string tag);
        opcode = op;
        funct  = fn;
        zero   = z;
        build_trace(op, fn, z);
        foreach (exp_q[i]) check($sformatf("%s op=%b fn=%b step%0d", tag, op, fn, i), exp_q[i]);
    endtask

    outs_t e;
    logic [5:0] ops[6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2};
    logic [5:0] fns[5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};

    initial begin
        reset  = 1'b1;
        opcode = 6'd0;
        funct  = 6'd0;
        zero   = 1'b0;
        @(posedge clk);
        #1;
        e = fetch_cycle(); e.pc_en = 1'b0; e.ir_write = 1'b0;
        check("reset_hold0", e);
        check("reset_hold1", e);
        reset = 1'b0;

        run_instr(6'd35, 6'd0, 1'b0, "lw");
        run_instr(6'd0, 6'd42, 1'b0, "slt");
        run_instr(6'd4, 6'd0, 1'b1, "beq_taken");
        run_instr(6'd4, 6'd0, 1'b0, "beq_not_taken");
        run_instr(6'd2, 6'd0, 1'b1, "jump");
        run_instr(6'd63, 6'd0, 1'b0, "illegal_op");
        run_instr(6'd0, 6'd0, 1'b0, "illegal_funct");

        // Abort a store in its write cycle: reset held for three cycles
        opcode = 6'd43;
        funct  = 6'd0;
        zero   = 1'b0;
        build_trace(6'd43, 6'd0, 1'b0);
        for (int i = 0; i < 3; i++) check($sformatf("sw_pre_reset step%0d", i), exp_q[i]);
        reset = 1'b1;
        e = '0; e.iord = 1'b1;
        check("reset_in_memwr", e);
        e = fetch_cycle(); e.pc_en = 1'b0; e.ir_write = 1'b0;
        check("reset_memwr_hold1", e);
        check("reset_memwr_hold2", e);
        reset = 1'b0;
        run_instr(6'd8, 6'd0, 1'b0, "addi_after_reset");

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 7) < 7) ? ops[$urandom_range(0, 5)] : 6'($urandom);
            fn = ($urandom_range(0, 4) < 4) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(op, fn, 1'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main controller for the multicycle MIPS datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback, and drives the 3-bit ALU control code consumed by the ALU. It sits beside the datapath in the processor top level. It receives the instruction opcode and funct fields plus the ALU `zero` flag, and returns all datapath enables and mux selects.

## Interface
Parameters: none.

Ports:
- `clk` — input, 1 — single clock; all state changes on rising edge.
- `reset` — input, 1 — synchronous, active-high.
- `opcode` — input, 6 — instr[31:26] from the instruction register.
- `funct` — input, 6 — instr[5:0] from the instruction register.
- `zero` — input, 1 — ALU zero flag.
- `alu_control` — output, 3 — 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `alu_src_a` — output, 1 — 0 = PC, 1 = register A.
- `alu_src_b` — output, 2 — 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `pc_src` — output, 2 — 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_en` — output, 1 — PC load enable, equal to pc_write | (branch & zero).
- `iord` — output, 1 — memory address select: 0 = PC, 1 = ALUOut.
- `mem_write` — output, 1 — data memory write enable.
- `ir_write` — output, 1 — instruction register load enable.
- `reg_dst` — output, 1 — 0 = rt, 1 = rd.
- `mem_to_reg` — output, 1 — 0 = ALUOut, 1 = memory data.
- `reg_write` — output, 1 — register file write enable.
- `illegal_instr` — output, 1 — one-cycle pulse in DECODE for an unsupported opcode or funct.

## Operation
States and their actions (unlisted outputs are 0):
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_control=ADD, pc_src=00, pc_write=1. Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=ADD (precomputes the branch target).
  - lw/sw → MEMADR.
  - R-type → RTYPEEX.
  - beq → BEQEX.
  - addi → ADDIEX.
  - j → JEX.
  - Anything else → FETCH with illegal_instr=1.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next: lw → MEMRD; sw → MEMWR.
- MEMRD: iord=1. Next: MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEMWR: iord=1, mem_write=1. Next: FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_control from funct. Next: RTYPEWB.
- RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, branch=1. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD. Next: ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
- JEX: pc_src=10, pc_write=1. Next: FETCH.

Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.

Funct map: 100000 → ADD, 100010 → SUB, 100100 → AND, 100101 → OR, 101010 → SLT.
- An unsupported funct with R-type opcode is detected in DECODE. It pulses illegal_instr and returns to FETCH. No register write occurs.

## Timing
- Reset:
  - While reset=1, pc_en, ir_write, mem_write, reg_write and illegal_instr are forced to 0.
  - At the first rising edge with reset=1, the state becomes FETCH. Mux selects then take FETCH values.
  - Reset in any state, mid-instruction, aborts the instruction with no further writes. The state is FETCH on the next edge.
- Outputs:
  - All outputs are combinational decodes of the state register.
  - alu_control additionally depends on funct in RTYPEEX.
  - pc_en additionally depends on zero in BEQEX. zero is sampled in the same cycle (Mealy path).
- Cycles per instruction, FETCH through the last state inclusive:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - Illegal instruction: 2
- opcode/funct are stable from the cycle after FETCH until the next FETCH; the controller relies on this.

## Structure
- Package `mips_pkg` holds:
  - Opcode constants.
  - Funct constants.
  - ALU op codes (AND=000, OR=001, ADD=010, SUB=110, SLT=111), shared with the ALU.
  - The state enum (12 states).
- Sub-module `alu_decoder` maps {alu_op class (ADD / SUB / FUNCT), funct} to alu_control and a funct_valid flag. It is purely combinational.

## Test plan
- Reset held 3 cycles mid-MEMWR, then released → mem_write=0 during reset; first post-reset cycle in FETCH with ir_write=1, pc_en=1, alu_control=010.
- opcode=100011 (lw) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. iord=1 in MEMRD; reg_write=1 and mem_to_reg=1 only in cycle 5.
- opcode=000000, funct=101010 → RTYPEEX alu_control=111; RTYPEWB reg_dst=1, reg_write=1; 4 cycles total.
- opcode=000100 (beq) in BEQEX:
  - zero=1 → pc_en=1, pc_src=01, alu_control=110.
  - Repeated with zero=0 → pc_en=0.
- opcode=000010 (j) → JEX pc_src=10, pc_en=1. Then opcode=111111 → illegal_instr=1 for exactly one cycle in DECODE, no reg_write/mem_write, back to FETCH.
- opcode=000000, funct=000000 → illegal_instr=1 in DECODE, reg_write never asserted.
